// File: rtl/pcr_reagent_sequencer.sv
// PCR premix reagent sequencer: dispenses each inlet in index order with the
// shared pump running, separates reagents with a closed settle gap, then
// flushes the mixed product through the outlet valve.
module pcr_reagent_sequencer #(
   parameter int unsigned N_CH       = 6,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned FLUSH_CYC  = 64,
   parameter int unsigned DEF_DUR    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_data,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             cfg_err,
   output logic [N_CH-1:0]  valve_open,
   output logic             out_valve,
   output logic             pump_en,
   output logic [2:0]       cur_ch
);

   typedef enum logic [2:0] {
      IDLE,
      DISPENSE,
      SETTLE,
      FLUSH,
      DONE
   } state_t;

   state_t           state_q;
   logic [2:0]       ch_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] dur_q [N_CH];

   logic             busy_q;
   logic             done_q;
   logic             aborted_q;
   logic             cfg_err_q;
   logic [N_CH-1:0]  valve_q;
   logic             out_valve_q;
   logic             pump_q;
   logic [2:0]       cur_ch_q;

   logic             first_vld_d;
   logic [2:0]       first_ch_d;
   logic [CNT_W-1:0] first_dur_d;
   logic             next_vld_d;
   logic [2:0]       next_ch_d;
   logic [CNT_W-1:0] next_dur_d;
   logic             addr_ok_d;

   assign addr_ok_d = (32'(cfg_addr) < N_CH);

   // Duration registers: writable only in IDLE with a valid address; otherwise flag an error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            dur_q[i] <= CNT_W'(DEF_DUR);
         end
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= 1'b0;
         if (cfg_we) begin
            if (state_q != IDLE || !addr_ok_d) begin
               cfg_err_q <= 1'b1;
            end else begin
               for (int unsigned i = 0; i < N_CH; i++) begin
                  if (cfg_addr == 3'(i)) begin
                     dur_q[i] <= cfg_data;
                  end
               end
            end
         end
      end
   end

   // Find the lowest nonzero channel overall and the lowest nonzero channel above ch_q
   // (descending scan so the last hit is the lowest index)
   always_comb begin
      first_vld_d = 1'b0;
      first_ch_d  = '0;
      first_dur_d = '0;
      next_vld_d  = 1'b0;
      next_ch_d   = '0;
      next_dur_d  = '0;
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (dur_q[i-1] != '0) begin
            first_vld_d = 1'b1;
            first_ch_d  = 3'(i-1);
            first_dur_d = dur_q[i-1];
            if (3'(i-1) > ch_q) begin
               next_vld_d = 1'b1;
               next_ch_d  = 3'(i-1);
               next_dur_d = dur_q[i-1];
            end
         end
      end
   end

   // Sequencer FSM with registered drives; abort from any busy state returns to IDLE in one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         valve_q     <= '0;
         out_valve_q <= 1'b0;
         pump_q      <= 1'b0;
         cur_ch_q    <= '0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         if (state_q != IDLE && abort) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            aborted_q   <= 1'b1;
            valve_q     <= '0;
            out_valve_q <= 1'b0;
            pump_q      <= 1'b0;
            cur_ch_q    <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && !abort) begin
                     busy_q <= 1'b1;
                     pump_q <= 1'b1;
                     if (first_vld_d) begin
                        state_q  <= DISPENSE;
                        ch_q     <= first_ch_d;
                        cur_ch_q <= first_ch_d;
                        cnt_q    <= first_dur_d;
                        valve_q  <= N_CH'(1) << first_ch_d;
                     end else begin
                        state_q     <= FLUSH;
                        cnt_q       <= CNT_W'(FLUSH_CYC);
                        out_valve_q <= 1'b1;
                     end
                  end
               end
               DISPENSE: begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= SETTLE;
                     cnt_q   <= CNT_W'(SETTLE_CYC);
                     valve_q <= '0;
                     pump_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               SETTLE: begin
                  if (cnt_q == CNT_W'(1)) begin
                     pump_q <= 1'b1;
                     if (next_vld_d) begin
                        state_q  <= DISPENSE;
                        ch_q     <= next_ch_d;
                        cur_ch_q <= next_ch_d;
                        cnt_q    <= next_dur_d;
                        valve_q  <= N_CH'(1) << next_ch_d;
                     end else begin
                        state_q     <= FLUSH;
                        ch_q        <= '0;
                        cur_ch_q    <= '0;
                        cnt_q       <= CNT_W'(FLUSH_CYC);
                        out_valve_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               FLUSH: begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_q     <= DONE;
                     cnt_q       <= '0;
                     out_valve_q <= 1'b0;
                     pump_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  valve_q     <= '0;
                  out_valve_q <= 1'b0;
                  pump_q      <= 1'b0;
                  cur_ch_q    <= '0;
               end
            endcase
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign cfg_err    = cfg_err_q;
   assign valve_open = valve_q;
   assign out_valve  = out_valve_q;
   assign pump_en    = pump_q;
   assign cur_ch     = cur_ch_q;

endmodule

// File: tb/tb_pcr_reagent_sequencer.sv
// Bench for pcr_reagent_sequencer: expected per-cycle output traces are built
// from the channel durations held in a bench-side model.
module tb_pcr_reagent_sequencer;

   localparam int K_NONE  = 0;
   localparam int K_ABORT = 1;
   localparam int K_CFG   = 2;
   localparam int K_START = 3;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        aborted;
   logic        cfg_err;
   logic [5:0]  valve_open;
   logic        out_valve;
   logic        pump_en;
   logic [2:0]  cur_ch;

   int          n_checks;
   int          n_fail;
   int unsigned dur_m [6];
   logic [14:0] trace_q [$];
   logic [14:0] obs_w;

   pcr_reagent_sequencer #(
      .N_CH      (6),
      .CNT_W     (16),
      .SETTLE_CYC(8),
      .FLUSH_CYC (64),
      .DEF_DUR   (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .cfg_err   (cfg_err),
      .valve_open(valve_open),
      .out_valve (out_valve),
      .pump_en   (pump_en),
      .cur_ch    (cur_ch)
   );

   // bit layout: busy done aborted cfg_err out_valve pump cur_ch[2:0] valve[5:0]
   assign obs_w = {busy, done, aborted, cfg_err, out_valve, pump_en, cur_ch, valve_open};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] pk(input logic b, input logic dn, input logic ab,
                                      input logic ce, input logic ov, input logic pe,
                                      input logic [2:0] ch, input logic [5:0] v);
      return {b, dn, ab, ce, ov, pe, ch, v};
   endfunction

   // Trace of one complete run: per nonzero channel dur cycles open + 8 closed, 64 flush, 1 done
   function automatic void build_trace();
      logic [5:0] oh;
      trace_q.delete();
      for (int c = 0; c < 6; c++) begin
         if (dur_m[c] != 0) begin
            oh = 6'b000001 << c;
            for (int unsigned k = 0; k < dur_m[c]; k++) trace_q.push_back(pk(1, 0, 0, 0, 0, 1, 3'(c), oh));
            for (int k = 0; k < 8; k++) trace_q.push_back(pk(1, 0, 0, 0, 0, 0, 3'(c), 6'd0));
         end
      end
      for (int k = 0; k < 64; k++) trace_q.push_back(pk(1, 0, 0, 0, 1, 1, 3'd0, 6'd0));
      trace_q.push_back(pk(1, 1, 0, 0, 0, 0, 3'd0, 6'd0));
   endfunction

   // Safety properties on every cycle
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if ($countones(valve_open) > 1 || (out_valve && |valve_open)) begin
            n_fail++;
            $display("FAIL valve_exclusive valve_open=%b out_valve=%b required onehot0 and no overlap", valve_open, out_valve);
         end
      end
   end

   task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
      logic exp_err;
      exp_err = (a >= 3'd6);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
      n_checks++;
      if (cfg_err !== exp_err) begin
         n_fail++;
         $display("FAIL cfg_write addr=%0d cfg_err=%b required %b", a, cfg_err, exp_err);
      end
      if (!exp_err) dur_m[a] = d;
   endtask

   task automatic write_all(input int unsigned d0, input int unsigned d1, input int unsigned d2,
                            input int unsigned d3, input int unsigned d4, input int unsigned d5);
      cfg_write(3'd0, 16'(d0)); cfg_write(3'd1, 16'(d1)); cfg_write(3'd2, 16'(d2));
      cfg_write(3'd3, 16'(d3)); cfg_write(3'd4, 16'(d4)); cfg_write(3'd5, 16'(d5));
   endtask

   // Start a run from IDLE and check every cycle against the model trace, with optional injection
   task automatic run_seq(input string name, input int kind, input int at,
                          input bit wr, input logic [2:0] wa, input logic [15:0] wd);
      logic [14:0] exp;
      bit          was_aborted;
      was_aborted = 0;
      build_trace();
      start = 1'b1;
      if (wr) begin cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; end
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      if (wr && wa < 3'd6) dur_m[wa] = int'(wd);
      for (int t = 0; t < trace_q.size(); t++) begin
         exp = trace_q[t];
         if (kind == K_CFG && t == at + 1) exp[11] = 1'b1;
         n_checks++;
         if (obs_w !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h required=%h", name, t, obs_w, exp);
         end
         if (t == at) begin
            case (kind)
               K_ABORT: abort = 1'b1;
               K_CFG:   begin cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 16'd99; end
               K_START: start = 1'b1;
               default: ;
            endcase
         end
         @(negedge clk);
         start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
         if (kind == K_ABORT && t == at) begin
            n_checks++;
            if (obs_w !== pk(0, 0, 1, 0, 0, 0, 3'd0, 6'd0)) begin
               n_fail++;
               $display("FAIL %s abort_pulse got=%h required=%h", name, obs_w, pk(0, 0, 1, 0, 0, 0, 3'd0, 6'd0));
            end
            was_aborted = 1;
            break;
         end
      end
      if (was_aborted) @(negedge clk);
      n_checks++;
      if (obs_w !== 15'd0) begin
         n_fail++;
         $display("FAIL %s idle_after got=%h required=0000", name, obs_w);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; abort = 1'b0;
      for (int c = 0; c < 6; c++) dur_m[c] = 16;
      repeat (3) @(negedge clk);
      n_checks++;
      if (obs_w !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h required=0000", obs_w);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs_w !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_release got=%h required=0000", obs_w);
      end
   endtask

   task automatic test_defaults();
      run_seq("defaults", K_NONE, -1, 0, 3'd0, 16'd0);
   endtask

   task automatic test_durations();
      write_all(5, 0, 3, 0, 0, 2);
      run_seq("abort_valve2", K_ABORT, 15, 0, 3'd0, 16'd0);
      run_seq("durations", K_NONE, -1, 0, 3'd0, 16'd0);
      run_seq("cfg_while_busy", K_CFG, 20, 0, 3'd0, 16'd0);
      run_seq("reg_unchanged", K_NONE, -1, 0, 3'd0, 16'd0);
   endtask

   task automatic test_all_zero();
      write_all(0, 0, 0, 0, 0, 0);
      run_seq("all_zero", K_NONE, -1, 0, 3'd0, 16'd0);
   endtask

   task automatic test_cfg_errors();
      cfg_write(3'd7, 16'd5);
      cfg_write(3'd6, 16'd5);
      @(negedge clk);
      n_checks++;
      if (cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_err_one_cycle got=%b required 0", cfg_err);
      end
      run_seq("after_bad_addr", K_NONE, -1, 0, 3'd0, 16'd0);
   endtask

   task automatic test_start_abort_idle();
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (obs_w !== 15'd0) begin
            n_fail++;
            $display("FAIL start_abort_idle cycle=%0d got=%h required=0000", k, obs_w);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_cfg_with_start();
      write_all(2, 0, 0, 1, 0, 0);
      run_seq("cfg_with_start_old", K_NONE, -1, 1, 3'd0, 16'd7);
      run_seq("cfg_with_start_new", K_NONE, -1, 0, 3'd0, 16'd0);
   endtask

   task automatic test_back_to_back();
      write_all(0, 3, 0, 0, 1, 0);
      build_trace();
      run_seq("start_in_done", K_START, trace_q.size() - 1, 0, 3'd0, 16'd0);
      run_seq("back_to_back", K_START, 3, 0, 3'd0, 16'd0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         for (int c = 0; c < 6; c++) begin
            if ($urandom_range(0, 2) == 0) cfg_write(3'(c), 16'd0);
            else cfg_write(3'(c), 16'($urandom_range(1, 10)));
         end
         cfg_write(3'($urandom_range(6, 7)), 16'($urandom_range(0, 65535)));
         run_seq("random", K_NONE, -1, 0, 3'd0, 16'd0);
      end
   endtask

   task automatic test_async_reset();
      write_all(4, 4, 4, 4, 4, 4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_w !== 15'd0) begin
         n_fail++;
         $display("FAIL async_reset got=%h required=0000", obs_w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) dur_m[c] = 16;
      @(negedge clk);
      run_seq("defaults_after_reset", K_NONE, -1, 0, 3'd0, 16'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_defaults();
      test_durations();
      test_all_zero();
      test_cfg_errors();
      test_start_abort_idle();
      test_cfg_with_start();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
